// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D): grant to response in 3 cycles minimum.
// Backpressure: the command is held in ISSUE until m_gnt; requesters only see a grant while IDLE.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_ctrl,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              m_req,
   output logic              m_we,
   output logic [2:0]        m_ctrl,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_gnt,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0]      CTRL_LW  = 3'b010;
   localparam logic            OWN_I    = 1'b0;
   localparam logic            OWN_D    = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic             owner;
   logic             last_owner;
   logic [CNT_W-1:0] cnt;
   logic             any_req;
   logic             win_d;
   logic             grant_ok;
   logic             wait_done;

   // A tie goes to whoever did not own the port last.
   always_comb begin
      any_req   = i_req | d_req;
      win_d     = d_req & (~i_req | (last_owner == OWN_I));
      grant_ok  = rst_n & (state == IDLE);
      wait_done = m_rvalid | (cnt == CNT_LAST);
   end

   assign i_gnt = grant_ok & i_req & ~win_d;
   assign d_gnt = grant_ok & win_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= OWN_I;
         last_owner <= OWN_I;
         cnt        <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_ctrl     <= 3'b000;
         m_addr     <= '0;
         m_wdata    <= '0;
         i_rvalid   <= 1'b0;
         i_rdata    <= '0;
         i_err      <= 1'b0;
         d_rvalid   <= 1'b0;
         d_rdata    <= '0;
         d_err      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= win_d;
                  last_owner <= win_d;
                  m_req      <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
                  if (win_d) begin
                     m_we    <= d_we;
                     m_ctrl  <= d_ctrl;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end else begin
                     m_we    <= 1'b0;
                     m_ctrl  <= CTRL_LW;
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                  end
               end
            end
            ISSUE: begin
               if (m_gnt) begin
                  m_req <= 1'b0;
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               // A response landing in the expiry cycle beats the timeout.
               if (wait_done) begin
                  state <= RESP;
                  if (owner == OWN_D) begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= m_rvalid ? m_rdata : '0;
                     d_err    <= ~m_rvalid;
                  end else begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= m_rvalid ? m_rdata : '0;
                     i_err    <= ~m_rvalid;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               i_rvalid <= 1'b0;
               i_rdata  <= '0;
               i_err    <= 1'b0;
               d_rvalid <= 1'b0;
               d_rdata  <= '0;
               d_err    <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector table plus hand sequences for round-robin, timeout and timeout race.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        rst_n;
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [2:0]  d_ctrl;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        m_gnt;
      logic        m_rvalid;
      logic [31:0] m_rdata;
   } in_t;

   typedef struct packed {
      logic        i_gnt;
      logic        d_gnt;
      logic        i_rvalid;
      logic        i_err;
      logic [31:0] i_rdata;
      logic        d_rvalid;
      logic        d_err;
      logic [31:0] d_rdata;
      logic        m_req;
      logic        m_we;
      logic [2:0]  m_ctrl;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic        busy;
   } out_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, i_req, d_req, d_we, m_gnt, m_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [2:0]  d_ctrl;
   logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
   logic        m_req, m_we, busy;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [2:0]  m_ctrl;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t tv[$];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_ctrl(m_ctrl), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
   );

   function automatic in_t nin();
      in_t t;
      t = '0;
      t.rst_n = 1'b1;
      return t;
   endfunction

   function automatic out_t cur_out();
      out_t o;
      o.i_gnt = i_gnt;       o.d_gnt = d_gnt;
      o.i_rvalid = i_rvalid; o.i_err = i_err;   o.i_rdata = i_rdata;
      o.d_rvalid = d_rvalid; o.d_err = d_err;   o.d_rdata = d_rdata;
      o.m_req = m_req;       o.m_we = m_we;     o.m_ctrl = m_ctrl;
      o.m_addr = m_addr;     o.m_wdata = m_wdata;
      o.busy = busy;
      return o;
   endfunction

   task automatic apply(input in_t t);
      rst_n = t.rst_n;   i_req = t.i_req;       i_addr = t.i_addr;
      d_req = t.d_req;   d_we = t.d_we;         d_ctrl = t.d_ctrl;
      d_addr = t.d_addr; d_wdata = t.d_wdata;
      m_gnt = t.m_gnt;   m_rvalid = t.m_rvalid; m_rdata = t.m_rdata;
   endtask

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_t t;
      t = '0;
      apply(t);
      tick();
      tick();
   endtask

   task automatic add(input string nm, input in_t t, input out_t o);
      vec_t v;
      v.name = nm;
      v.in   = t;
      v.exp  = o;
      tv.push_back(v);
   endtask

   task automatic build_table();
      in_t  t;
      out_t o;
      t = nin(); t.rst_n = 0; t.i_req = 1; t.d_req = 1;
      o = '0;
      add("reset_state", t, o);
      t = nin(); t.d_req = 1; t.d_ctrl = 3'b010; t.d_addr = 32'h100;
      o = '0; o.d_gnt = 1;
      add("load_gnt", t, o);
      t = nin(); t.m_gnt = 1;
      o = '0; o.m_req = 1; o.m_ctrl = 3'b010; o.m_addr = 32'h100; o.busy = 1;
      add("load_issue", t, o);
      t = nin(); t.m_rvalid = 1; t.m_rdata = 32'hDEADBEEF;
      o = '0; o.m_ctrl = 3'b010; o.m_addr = 32'h100; o.busy = 1;
      add("load_wait", t, o);
      t = nin();
      o = '0; o.d_rvalid = 1; o.d_rdata = 32'hDEADBEEF; o.m_ctrl = 3'b010; o.m_addr = 32'h100; o.busy = 1;
      add("load_resp", t, o);
      t = nin(); t.i_req = 1; t.i_addr = 32'h200; t.m_rvalid = 1; t.m_rdata = 32'h99;
      o = '0; o.i_gnt = 1; o.m_ctrl = 3'b010; o.m_addr = 32'h100;
      add("fetch_gnt", t, o);
      t = nin();
      o = '0; o.m_req = 1; o.m_ctrl = 3'b010; o.m_addr = 32'h200; o.busy = 1;
      add("fetch_issue", t, o);
      t = nin(); t.m_gnt = 1;
      add("fetch_issue_gnt", t, o);
      t = nin(); t.m_rvalid = 1; t.m_rdata = 32'h12345678;
      o = '0; o.m_ctrl = 3'b010; o.m_addr = 32'h200; o.busy = 1;
      add("fetch_wait", t, o);
      t = nin();
      o = '0; o.i_rvalid = 1; o.i_rdata = 32'h12345678; o.m_ctrl = 3'b010; o.m_addr = 32'h200; o.busy = 1;
      add("fetch_resp", t, o);
      t = nin(); t.i_req = 1; t.i_addr = 32'h204; t.d_req = 1; t.d_we = 1;
      t.d_ctrl = 3'b110; t.d_addr = 32'h300; t.d_wdata = 32'h0000ABCD;
      o = '0; o.d_gnt = 1; o.m_ctrl = 3'b010; o.m_addr = 32'h200;
      add("tie_after_fetch", t, o);
      t = nin(); t.d_ctrl = 3'b000; t.d_wdata = 32'hFFFFFFFF;
      o = '0; o.m_req = 1; o.m_we = 1; o.m_ctrl = 3'b110; o.m_addr = 32'h300;
      o.m_wdata = 32'h0000ABCD; o.busy = 1;
      add("store_hold0", t, o);
      add("store_hold1", t, o);
      add("store_hold2", t, o);
      t.m_gnt = 1;
      add("store_hold3", t, o);
      t = nin();
      o.m_req = 0;
      add("store_wait", t, o);
      t = nin(); t.m_rvalid = 1;
      add("store_ack_in", t, o);
      t = nin();
      o.d_rvalid = 1;
      add("store_resp", t, o);
      t = nin(); t.d_req = 1; t.d_addr = 32'h44;
      o = '0; o.d_gnt = 1; o.m_we = 1; o.m_ctrl = 3'b110; o.m_addr = 32'h300; o.m_wdata = 32'h0000ABCD;
      add("lb_gnt", t, o);
      t = nin(); t.m_gnt = 1;
      o = '0; o.m_req = 1; o.m_addr = 32'h44; o.busy = 1;
      add("lb_issue", t, o);
      t = nin(); t.rst_n = 0; t.m_rvalid = 1; t.m_rdata = 32'h55; t.i_req = 1; t.d_req = 1;
      o = '0; o.m_addr = 32'h44; o.busy = 1;
      add("rst_in_wait", t, o);
      t = nin(); t.i_req = 1; t.i_addr = 32'h500; t.d_req = 1; t.d_ctrl = 3'b100; t.d_addr = 32'h80;
      o = '0; o.d_gnt = 1;
      add("post_rst_tie", t, o);
      t = nin(); t.i_req = 1; t.i_addr = 32'h500;
      o = '0; o.m_req = 1; o.m_ctrl = 3'b100; o.m_addr = 32'h80; o.busy = 1;
      add("post_rst_issue", t, o);
   endtask

   initial begin
      in_t t;
      build_table();
      do_reset();

      foreach (tv[k]) begin
         apply(tv[k].in);
         #1;
         check(tv[k].name, cur_out(), tv[k].exp);
         @(posedge clk);
         #1;
      end

      // Both requesters held high: grants every 4 cycles, D first, alternating.
      do_reset();
      t = nin(); t.i_req = 1; t.i_addr = 32'hA0; t.d_req = 1; t.d_addr = 32'hB0;
      t.m_gnt = 1; t.m_rvalid = 1; t.m_rdata = 32'h1;
      apply(t);
      for (int k = 0; k < 16; k++) begin
         #1;
         if (k % 4 == 0)
            check($sformatf("rr_gnt_%0d", k), {i_gnt, d_gnt}, ((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
         else
            check($sformatf("rr_gnt_%0d", k), {i_gnt, d_gnt}, 2'b00);
         if (k % 4 == 1)
            check($sformatf("rr_addr_%0d", k), m_addr, ((k / 4) % 2 == 0) ? 32'hB0 : 32'hA0);
         @(posedge clk);
         #1;
      end

      // Fetch timeout with TIMEOUT=4, then a late response in IDLE.
      do_reset();
      t = nin(); t.i_req = 1; t.i_addr = 32'h400;
      apply(t); #1;
      check("to_gnt", {i_gnt, d_gnt}, 2'b10);
      tick();
      apply(nin()); #1;
      check("to_issue_wait_gnt", m_req, 1'b1);
      tick();
      t = nin(); t.m_gnt = 1;
      apply(t); #1;
      check("to_issue_last", m_req, 1'b1);
      tick();
      for (int w = 1; w <= 4; w++) begin
         apply(nin()); #1;
         check($sformatf("to_wait_%0d", w), {i_rvalid, busy}, 2'b01);
         tick();
      end
      #1;
      check("to_resp", {i_rvalid, i_err, i_rdata, d_rvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
      tick();
      t = nin(); t.m_rvalid = 1; t.m_rdata = 32'h77;
      apply(t); #1;
      check("to_idle_busy", busy, 1'b0);
      tick();
      apply(nin()); #1;
      check("to_late_drop", {i_rvalid, d_rvalid, busy}, 3'b000);

      // Response arriving exactly in the expiry cycle wins over the timeout.
      do_reset();
      t = nin(); t.d_req = 1; t.d_ctrl = 3'b011; t.d_addr = 32'h600;
      apply(t); #1;
      check("race_gnt", {i_gnt, d_gnt}, 2'b01);
      tick();
      t = nin(); t.m_gnt = 1;
      apply(t);
      tick();
      for (int w = 1; w <= 3; w++) begin
         apply(nin()); #1;
         check($sformatf("race_wait_%0d", w), d_rvalid, 1'b0);
         tick();
      end
      t = nin(); t.m_rvalid = 1; t.m_rdata = 32'hCAFEF00D;
      apply(t);
      tick();
      apply(nin()); #1;
      check("race_resp", {d_rvalid, d_err, d_rdata, i_rvalid}, {1'b1, 1'b0, 32'hCAFEF00D, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port. It shares one memory port between instruction fetch (I) and load/store (D) traffic. Each transaction goes through request, grant, wait, and response phases, with round-robin arbitration and a response timeout. It sits between the fetch/LSU stages and the memory, and passes the decoder's 3-bit memory-control code through unchanged.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 16: maximum cycles spent in WAIT before an error response. Legal range is ≥1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_req`  in  1  fetch request.
- `i_addr`  in  ADDR_W  fetch address.
- `i_gnt`  out  1  fetch command accepted; this cycle only.
- `i_rvalid`  out  1  fetch response valid; 1-cycle pulse.
- `i_rdata`  out  DATA_W  fetch read data.
- `i_err`  out  1  fetch timed out; qualified by `i_rvalid`.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_ctrl`  in  3  access code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `d_addr`  in  ADDR_W  load/store address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: as for the I side.
- `m_req`  out  1  memory command valid.
- `m_we`  out  1  memory write enable.
- `m_ctrl`  out  3  memory access code.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_gnt`  in  1  memory accepts the command.
- `m_rvalid`  in  1  memory response valid.
- `m_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Arbitration when only one requester is active: that requester wins.
  - Arbitration when both are active: the winner is the opposite of `last_owner`. `last_owner` resets to I, so D wins the first tie.
  - `x_gnt` is asserted combinationally for the winner in this cycle. At most one grant is ever high.
  - On the clock edge the command is latched into registers:
    - D command: `m_we` = `d_we`, `m_ctrl` = `d_ctrl`, `m_addr` = `d_addr`, `m_wdata` = `d_wdata`.
    - I command: `m_we` = 0, `m_ctrl` = 010, `m_addr` = `i_addr`, `m_wdata` = 0.
  - `owner` and `last_owner` are updated to the winner, then the FSM moves to ISSUE.
  - With no request, the FSM stays in IDLE.
- **ISSUE**
  - `m_req` = 1, and all `m_*` command outputs are held stable.
  - `m_gnt` = 1 moves the FSM to WAIT and clears the timeout counter.
  - There is no timeout in this state; it waits for `m_gnt` indefinitely.
- **WAIT**
  - `m_req` = 0 and the counter increments every cycle.
  - `m_rvalid` = 1: latch `m_rdata`, set err = 0, go to RESP.
  - Counter reaches `TIMEOUT - 1` with no `m_rvalid`: rdata = 0, err = 1, go to RESP.
  - If `m_rvalid` arrives in the same cycle the counter expires, it wins (err = 0).
- **RESP**
  - The owner's `x_rvalid` = 1 with its `x_rdata` and `x_err`. The other side's rvalid stays 0.
  - Next state is IDLE unconditionally.
- General rules:
  - Stores also produce an `x_rvalid` acknowledge, with rdata = 0 unless the memory returns data.
  - `m_rvalid` and `m_gnt` are ignored outside WAIT and ISSUE respectively. Late responses after a timeout are dropped.
  - Requesters may drop `x_req` after `x_gnt`. Dropping `x_req` before the grant is legal, and no transaction is generated.
  - Only one transaction is outstanding at a time.

## Timing
- **Reset:** with `rst_n` = 0 at an edge:
  - State becomes IDLE, `last_owner` = I, and the counter is cleared.
  - All registered outputs (`m_req`, `m_we`, `m_ctrl`, `m_addr`, `m_wdata`, `x_rvalid`, `x_rdata`, `x_err`, `busy`) become 0.
  - `i_gnt` and `d_gnt` are forced to 0 while `rst_n` = 0.
- **Reset mid-transaction:** the transaction is abandoned with no response pulse, and `m_req` is 0 from the following cycle.
- **Minimum latency:**
  - c0: `x_req` and `x_gnt`.
  - c1: `m_req`, and `m_gnt` returned.
  - c2: `m_rvalid`.
  - c3: `x_rvalid`.
  - Total: 3 cycles from grant to response. Back-to-back grants are 4 cycles apart.
- **Timeout response:** appears `TIMEOUT` + 1 cycles after leaving ISSUE.

## Test plan
- **Single load:**
  - Stimulus: `d_req` with `d_ctrl` = 010, addr 0x100. Memory grants immediately and returns 0xDEADBEEF one cycle later.
  - Required: `d_gnt` at c0; `m_req`/`m_ctrl` = 010 at c1; `d_rvalid` with rdata 0xDEADBEEF and `d_err` = 0 at c3; `i_rvalid` stays 0.
- **Tie round-robin:**
  - Stimulus: `i_req` and `d_req` both held high from reset.
  - Required: grant order is D, I, D, I; `m_addr` alternates between the two addresses; grants are 4 cycles apart.
- **Store passthrough:**
  - Stimulus: `d_we` = 1, `d_ctrl` = 110, wdata 0x0000ABCD, with `m_gnt` delayed 3 cycles.
  - Required: `m_req`, `m_we` = 1, `m_ctrl` = 110, and `m_wdata` are held stable for 4 cycles; `d_rvalid` is asserted after the response.
- **Timeout:**
  - Stimulus: `TIMEOUT` = 4, fetch granted, `m_rvalid` never arrives.
  - Required: `i_rvalid` = 1 with `i_err` = 1 and `i_rdata` = 0, 5 cycles after ISSUE exits. A late `m_rvalid` in IDLE produces no pulse.
- **Reset mid-WAIT:**
  - Stimulus: assert `rst_n` = 0 during WAIT.
  - Required: no `x_rvalid`; all outputs 0 next cycle; after release, the first tie goes to D.
- **Race at timeout:**
  - Stimulus: `m_rvalid` arrives exactly in the expiry cycle.
  - Required: response with err = 0 and the data returned by the memory.
